// File: rtl/uart_rx_pkg.sv
// Shared types for the UART receive buffer: the stored entry layout and a helper
// that tells whether an entry carries a framing/parity error.
package uart_rx_pkg;

  localparam int UART_DATA_W = 8;

  typedef struct packed {
    logic [UART_DATA_W-1:0] data;
    logic                   perr;
    logic                   serr;
  } rx_entry_t;

  function automatic logic frame_err(input rx_entry_t e);
    return e.perr | e.serr;
  endfunction

endpackage

// File: rtl/uart_rx_buffer_if.sv
// UART-side capture signals plus the host-side valid/ready read port.
// master = the buffer, slave = the UART receiver / host driving it.
interface uart_rx_buffer_if;
  import uart_rx_pkg::*;

  logic [UART_DATA_W-1:0] data_out;
  logic                   data_ready;
  logic                   parity_error;
  logic                   stop_error;
  logic                   rd_valid;
  logic                   rd_ready;
  logic [UART_DATA_W-1:0] rd_data;
  logic                   rd_perr;
  logic                   rd_serr;

  modport master (
    input  data_out, data_ready, parity_error, stop_error, rd_ready,
    output rd_valid, rd_data, rd_perr, rd_serr
  );

  modport slave (
    output data_out, data_ready, parity_error, stop_error, rd_ready,
    input  rd_valid, rd_data, rd_perr, rd_serr
  );

endinterface

// File: rtl/uart_rx_fifo.sv
// Show-ahead synchronous FIFO of rx_entry_t. The head entry is kept in a register
// so it resets to zero and holds its last value while the FIFO is empty.
module uart_rx_fifo
  import uart_rx_pkg::*;
#(
  parameter  int DEPTH = 16,
  localparam int AW    = $clog2(DEPTH),
  localparam int CW    = $clog2(DEPTH + 1)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          wr_en,
  input  rx_entry_t     wr_data,
  input  logic          rd_en,
  output rx_entry_t     rd_data,
  output logic [CW-1:0] count,
  output logic          full,
  output logic          empty
);

  localparam logic [AW-1:0] PTR_ONE = AW'(1'b1);
  localparam logic [CW-1:0] CNT_ONE = CW'(1'b1);

  rx_entry_t     mem_r [DEPTH];
  rx_entry_t     head_r;
  logic [AW-1:0] wr_ptr_r;
  logic [AW-1:0] rd_ptr_r;
  logic [CW-1:0] count_r;
  logic [CW-1:0] count_nxt_s;
  logic          full_r;
  logic          empty_r;
  logic          wr_do_s;
  logic          rd_do_s;

  // Effective push/pop and next occupancy; a push into a full FIFO needs a same-cycle pop.
  always_comb begin
    rd_do_s     = rd_en && !empty_r;
    wr_do_s     = wr_en && (!full_r || rd_do_s);
    count_nxt_s = count_r;
    case ({wr_do_s, rd_do_s})
      2'b10:   count_nxt_s = count_r + CNT_ONE;
      2'b01:   count_nxt_s = count_r - CNT_ONE;
      default: count_nxt_s = count_r;
    endcase
  end

  // Storage array, no reset needed since only written slots are ever read.
  always_ff @(posedge clk) begin
    if (wr_do_s) begin
      mem_r[wr_ptr_r] <= wr_data;
    end
  end

  // Pointers, status and the registered head entry.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_r <= {AW{1'b0}};
      rd_ptr_r <= {AW{1'b0}};
      count_r  <= {CW{1'b0}};
      full_r   <= 1'b0;
      empty_r  <= 1'b1;
      head_r   <= '{data: {UART_DATA_W{1'b0}}, perr: 1'b0, serr: 1'b0};
    end else begin
      if (wr_do_s) wr_ptr_r <= wr_ptr_r + PTR_ONE;
      if (rd_do_s) rd_ptr_r <= rd_ptr_r + PTR_ONE;
      count_r <= count_nxt_s;
      full_r  <= (count_nxt_s == CW'(DEPTH));
      empty_r <= (count_nxt_s == {CW{1'b0}});
      // With one entry left and a push, the new head is the entry being written.
      if (rd_do_s) begin
        if (count_r > CNT_ONE) head_r <= mem_r[rd_ptr_r + PTR_ONE];
        else if (wr_do_s)      head_r <= wr_data;
      end else if (wr_do_s && empty_r) begin
        head_r <= wr_data;
      end
    end
  end

  assign rd_data = head_r;
  assign count   = count_r;
  assign full    = full_r;
  assign empty   = empty_r;

endmodule

// File: rtl/uart_rx_buffer.sv
// UART receive buffer: rising-edge capture of data_ready into a FIFO, sticky overflow
// and a saturating error counter. UART_RX_DROP_ERR_EN discards errored frames.
module uart_rx_buffer
  import uart_rx_pkg::*;
#(
  parameter  int DEPTH     = 16,
  parameter  int ERR_CNT_W = 8,
  localparam int CW        = $clog2(DEPTH + 1)
) (
  input  logic                 clk,
  input  logic                 reset,
  uart_rx_buffer_if.master     bus,
  input  logic                 clr_ovf,
  output logic [CW-1:0]        count,
  output logic                 full,
  output logic                 overflow,
  output logic [ERR_CNT_W-1:0] err_cnt
);

  localparam logic [ERR_CNT_W-1:0] ERR_ONE = ERR_CNT_W'(1'b1);
  localparam logic [ERR_CNT_W-1:0] ERR_MAX = {ERR_CNT_W{1'b1}};

  rx_entry_t            entry_s;
  rx_entry_t            head_s;
  logic                 dr_prev_r;
  logic                 capture_s;
  logic                 err_s;
  logic                 store_s;
  logic                 rd_en_s;
  logic                 wr_en_s;
  logic                 ovf_set_s;
  logic                 fifo_full_s;
  logic                 fifo_empty_s;
  logic                 overflow_r;
  logic [ERR_CNT_W-1:0] err_cnt_r;

  // Capture decode, write qualification and overflow detection.
  always_comb begin
    entry_s   = '{data: bus.data_out, perr: bus.parity_error, serr: bus.stop_error};
    capture_s = bus.data_ready && !dr_prev_r;
    err_s     = frame_err(entry_s);
    rd_en_s   = bus.rd_ready && !fifo_empty_s;
`ifdef UART_RX_DROP_ERR_EN
    store_s   = capture_s && !err_s;
`else
    store_s   = capture_s;
`endif
    wr_en_s   = store_s && (!fifo_full_s || rd_en_s);
    ovf_set_s = store_s && fifo_full_s && !rd_en_s;
  end

  // Edge-detect history (resets high so a held level is not captured), overflow, error count.
  always_ff @(posedge clk) begin
    if (reset) begin
      dr_prev_r  <= 1'b1;
      overflow_r <= 1'b0;
      err_cnt_r  <= {ERR_CNT_W{1'b0}};
    end else begin
      dr_prev_r <= bus.data_ready;
      if (ovf_set_s)    overflow_r <= 1'b1;
      else if (clr_ovf) overflow_r <= 1'b0;
      if (capture_s && err_s && (err_cnt_r != ERR_MAX)) begin
        err_cnt_r <= err_cnt_r + ERR_ONE;
      end
    end
  end

  uart_rx_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk     (clk),
    .reset   (reset),
    .wr_en   (wr_en_s),
    .wr_data (entry_s),
    .rd_en   (rd_en_s),
    .rd_data (head_s),
    .count   (count),
    .full    (fifo_full_s),
    .empty   (fifo_empty_s)
  );

  assign bus.rd_valid = !fifo_empty_s;
  assign bus.rd_data  = head_s.data;
`ifdef UART_RX_DROP_ERR_EN
  assign bus.rd_perr  = 1'b0;
  assign bus.rd_serr  = 1'b0;
`else
  assign bus.rd_perr  = head_s.perr;
  assign bus.rd_serr  = head_s.serr;
`endif
  assign full     = fifo_full_s;
  assign overflow = overflow_r;
  assign err_cnt  = err_cnt_r;

endmodule

// File: tb/tb_uart_rx_buffer.sv
// Scoreboard bench for uart_rx_buffer: directed captures push expected entries,
// a negedge monitor pops and compares on every read handshake.
module tb_uart_rx_buffer;
  import uart_rx_pkg::*;

`ifdef UART_RX_DROP_ERR_EN
  localparam bit DROP = 1'b1;
`else
  localparam bit DROP = 1'b0;
`endif

  logic       clk;
  logic       reset;
  logic       clr_ovf;
  logic [4:0] count;
  logic       full;
  logic       overflow;
  logic [7:0] err_cnt;

  int checks   = 0;
  int failures = 0;
  logic [9:0] exp_q[$];

  uart_rx_buffer_if bus ();

  uart_rx_buffer #(.DEPTH(16), .ERR_CNT_W(8)) dut (
    .clk      (clk),
    .reset    (reset),
    .bus      (bus),
    .clr_ovf  (clr_ovf),
    .count    (count),
    .full     (full),
    .overflow (overflow),
    .err_cnt  (err_cnt)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Monitor: every handshake must match the head of the expected queue.
  always @(negedge clk) begin
    if (bus.rd_valid && bus.rd_ready) begin
      logic [9:0] got;
      logic [9:0] exp;
      got = {bus.rd_data, bus.rd_perr, bus.rd_serr};
      checks++;
      if (exp_q.size() == 0) begin
        failures++;
        $display("FAIL pop_unexpected got={%h,%b,%b} expected none", got[9:2], got[1], got[0]);
      end else begin
        exp = exp_q.pop_front();
        if (got !== exp) begin
          failures++;
          $display("FAIL pop_data got={%h,%b,%b} expected={%h,%b,%b}",
                   got[9:2], got[1], got[0], exp[9:2], exp[1], exp[0]);
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s got=%0d expected=%0d", name, act, exp);
    end
  endtask

  // One capture: one cycle high followed by one cycle low.
  task automatic cap(input logic [7:0] d, input logic pe, input logic se, input bit push);
    if (push) exp_q.push_back({d, pe, se});
    bus.data_out     = d;
    bus.parity_error = pe;
    bus.stop_error   = se;
    bus.data_ready   = 1'b1;
    tick();
    bus.data_ready   = 1'b0;
    bus.parity_error = 1'b0;
    bus.stop_error   = 1'b0;
    tick();
  endtask

  task automatic drain();
    int n;
    n = 0;
    bus.rd_ready = 1'b1;
    while (exp_q.size() != 0 && n < 64) begin
      tick();
      n++;
    end
    bus.rd_ready = 1'b0;
    chk("drain_done", exp_q.size(), 0);
    @(negedge clk);
    chk("drain_valid", int'(bus.rd_valid), 0);
    chk("drain_count", int'(count), 0);
  endtask

  initial begin
    reset = 1'b1;
    clr_ovf = 1'b0;
    bus.data_out = 8'h00;
    bus.data_ready = 1'b1;
    bus.parity_error = 1'b0;
    bus.stop_error = 1'b0;
    bus.rd_ready = 1'b0;
    repeat (3) tick();
    @(negedge clk);
    chk("rst_valid", int'(bus.rd_valid), 0);
    chk("rst_count", int'(count), 0);
    chk("rst_full", int'(full), 0);
    chk("rst_ovf", int'(overflow), 0);
    chk("rst_errcnt", int'(err_cnt), 0);
    chk("rst_data", int'({bus.rd_data, bus.rd_perr, bus.rd_serr}), 0);
    // data_ready already high at reset release must not capture
    tick();
    reset = 1'b0;
    repeat (2) tick();
    bus.data_ready = 1'b0;
    tick();
    chk("held_at_reset_count", int'(count), 0);

    // Single byte, capture latency, pop latency
    exp_q.push_back({8'hA5, 1'b0, 1'b0});
    bus.data_out = 8'hA5;
    bus.data_ready = 1'b1;
    tick();
    bus.data_ready = 1'b0;
    @(negedge clk);
    chk("single_valid", int'(bus.rd_valid), 1);
    chk("single_data", int'(bus.rd_data), 8'hA5);
    chk("single_count", int'(count), 1);
    tick();
    bus.rd_ready = 1'b1;
    tick();
    bus.rd_ready = 1'b0;
    @(negedge clk);
    chk("single_pop_valid", int'(bus.rd_valid), 0);
    chk("single_pop_count", int'(count), 0);
    chk("single_hold_data", int'(bus.rd_data), 8'hA5);

    // Level-held data_ready
    exp_q.push_back({8'h3C, 1'b0, 1'b0});
    bus.data_out = 8'h3C;
    bus.data_ready = 1'b1;
    repeat (5) tick();
    bus.data_ready = 1'b0;
    tick();
    chk("level_count", int'(count), 1);
    drain();

    // Overflow: 17 captures with 1-cycle gaps, no reads
    for (int i = 0; i < 17; i++) cap(8'(i), 1'b0, 1'b0, i < 16);
    chk("ovf_full", int'(full), 1);
    chk("ovf_flag", int'(overflow), 1);
    chk("ovf_count", int'(count), 16);
    // drop and clear in the same cycle: set wins
    bus.data_out = 8'h77;
    bus.data_ready = 1'b1;
    clr_ovf = 1'b1;
    tick();
    bus.data_ready = 1'b0;
    clr_ovf = 1'b0;
    tick();
    chk("ovf_set_wins", int'(overflow), 1);
    clr_ovf = 1'b1;
    tick();
    clr_ovf = 1'b0;
    chk("ovf_cleared", int'(overflow), 0);

    // Full: capture 0x55 alongside a pop
    exp_q.push_back({8'h55, 1'b0, 1'b0});
    bus.data_out = 8'h55;
    bus.data_ready = 1'b1;
    bus.rd_ready = 1'b1;
    tick();
    bus.data_ready = 1'b0;
    bus.rd_ready = 1'b0;
    tick();
    chk("full_rw_count", int'(count), 16);
    chk("full_rw_ovf", int'(overflow), 0);
    drain();

    // Error frames
    cap(8'h81, 1'b1, 1'b0, !DROP);
    cap(8'h42, 1'b0, 1'b1, !DROP);
    chk("err_cnt", int'(err_cnt), 2);
    chk("err_count", int'(count), DROP ? 0 : 2);
    chk("err_ovf", int'(overflow), 0);
    drain();

    // Reset mid-operation; edge during reset cycle ignored
    cap(8'h01, 1'b0, 1'b0, 1'b0);
    cap(8'h02, 1'b0, 1'b0, 1'b0);
    cap(8'h03, 1'b0, 1'b0, 1'b0);
    chk("pre_rst_count", int'(count), 3);
    reset = 1'b1;
    bus.data_out = 8'hEE;
    bus.data_ready = 1'b1;
    tick();
    reset = 1'b0;
    @(negedge clk);
    chk("mid_rst_count", int'(count), 0);
    chk("mid_rst_valid", int'(bus.rd_valid), 0);
    chk("mid_rst_errcnt", int'(err_cnt), 0);
    tick();
    bus.data_ready = 1'b0;
    tick();
    chk("rst_edge_ignored", int'(count), 0);

    // Wraparound: 40 bytes streamed with reads enabled
    bus.rd_ready = 1'b1;
    for (int i = 0; i < 40; i++) cap(8'h40 + 8'(i), 1'b0, 1'b0, 1'b1);
    drain();
    chk("wrap_ovf", int'(overflow), 0);

    chk("queue_empty", exp_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
